// File: rtl/user_input_port_pkg.sv
// Shared definitions for the operator input path.
// Holds the default debounce interval, synchroniser depth, the ENTER key index,
// key/switch widths and the encoding of the one-entry capture buffer FSM.
package user_input_port_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_ENTER_KEY       = 0;
  localparam int NUM_KEYS                = 4;
  localparam int SW_WIDTH                = 8;

  // Capture buffer state: FULL means din holds a value not yet taken.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/user_input_port_key_debouncer.sv
// key_debouncer: synchroniser plus debounce filter for one active-low pushbutton.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   key_raw  in  raw active-low key, asynchronous to clk
//   level    out debounced level, 1 = pressed
//   press    out one-cycle pulse on the cycle level rises
module key_debouncer
  import user_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   pressed_s;
  logic                   stable_r;
  logic                   press_r;
  logic [CNT_W-1:0]       cnt_r;

  // The synchroniser is reset to "released" so a key held through reset is
  // seen as a fresh press once reset is released.
  assign pressed_s = ~sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain for the raw key.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_raw};
    end
  end

  // Debounce: accept a new level only after it differs from stable for
  // DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
      press_r  <= 1'b0;
    end else if (pressed_s == stable_r) begin
      cnt_r    <= '0;
      press_r  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      stable_r <= pressed_s;
      cnt_r    <= '0;
      // Pulse only on released->pressed; releases give no pulse.
      press_r  <= pressed_s;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1);
      press_r  <= 1'b0;
    end
  end

  assign level = stable_r;
  assign press = press_r;

endmodule

// File: rtl/user_input_port.sv
// user_input_port: operator input side of the board I/O path.
// Debounces four active-low pushbuttons, synchronises eight data switches and
// captures the switch value into a one-entry buffer on an ENTER press. The
// buffer is offered downstream through a valid/ready handshake.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   key_raw[4]   raw active-low pushbuttons
//   sw_raw[8]    raw data switches (synchronised, not debounced)
//   gpi[4]       debounced key levels, 1 = pressed
//   gpi_press[4] one-cycle pulse per debounced press
//   din[8]       captured switch value
//   din_val      buffer holds an unconsumed value
//   din_rdy      consumer takes din this cycle when din_val is high
//   overrun      sticky flag: an ENTER press was dropped on a full buffer
//   overrun_clr  clears overrun (a simultaneous new drop wins)
module user_input_port
  import user_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int ENTER_KEY       = DEFAULT_ENTER_KEY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_KEYS-1:0] gpi,
  output logic [NUM_KEYS-1:0] gpi_press,
  output logic [SW_WIDTH-1:0] din,
  output logic                din_val,
  input  logic                din_rdy,
  output logic                overrun,
  input  logic                overrun_clr
);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_r;
  logic [SW_WIDTH-1:0]                  sw_synced_s;
  logic                                 enter_s;
  buf_state_e                           state_r;
  buf_state_e                           state_next_s;
  logic                                 din_load_s;
  logic                                 overrun_set_s;
  logic [SW_WIDTH-1:0]                  din_r;
  logic                                 overrun_r;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_key_debouncer (
      .clk    (clk),
      .reset  (reset),
      .key_raw(key_raw[i]),
      .level  (gpi[i]),
      .press  (gpi_press[i])
    );
  end

  // Switch synchroniser chain; switches are levels so no debounce is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync_r <= '0;
    end else begin
      sw_sync_r <= {sw_sync_r[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sw_synced_s = sw_sync_r[SYNC_STAGES-1];
  assign enter_s     = gpi_press[ENTER_KEY];

  // Buffer FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Buffer FSM next state: a press together with a transfer refills in place.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (enter_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (din_rdy && !enter_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Buffer FSM actions: when to load din and when a press is dropped.
  always_comb begin
    din_load_s    = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        din_load_s = enter_s;
      end
      ST_FULL: begin
        if (enter_s && din_rdy) begin
          din_load_s = 1'b1;
        end else if (enter_s) begin
          overrun_set_s = 1'b1;
        end else begin
          din_load_s    = 1'b0;
          overrun_set_s = 1'b0;
        end
      end
      default: begin
        din_load_s    = 1'b0;
        overrun_set_s = 1'b0;
      end
    endcase
  end

  // Data and overrun registers; din keeps its last value after a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (din_load_s) begin
        din_r <= sw_synced_s;
      end else begin
        din_r <= din_r;
      end
      // A dropped press in the same cycle as a clear keeps the flag set.
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign din     = din_r;
  assign din_val = (state_r == ST_FULL);
  assign overrun = overrun_r;

endmodule

// File: tb/tb_user_input_port.sv
module tb_user_input_port;

  logic       clk;
  logic       reset;
  logic [3:0] key_raw;
  logic [7:0] sw_raw;
  logic [3:0] gpi;
  logic [3:0] gpi_press;
  logic [7:0] din;
  logic       din_val;
  logic       din_rdy;
  logic       overrun;
  logic       overrun_clr;

  int tests_run = 0;
  int failures  = 0;

  typedef struct packed {
    logic       is_xfer;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  user_input_port #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .ENTER_KEY      (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .sw_raw     (sw_raw),
    .gpi        (gpi),
    .gpi_press  (gpi_press),
    .din        (din),
    .din_val    (din_val),
    .din_rdy    (din_rdy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests_run++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push_press(input logic [3:0] vec);
    exp_t e;
    e.is_xfer = 1'b0;
    e.data    = {4'h0, vec};
    exp_q.push_back(e);
  endtask

  task automatic push_xfer(input logic [7:0] val);
    exp_t e;
    e.is_xfer = 1'b1;
    e.data    = val;
    exp_q.push_back(e);
  endtask

  // Monitor: every press pulse and every handshake transfer must match the
  // next expected event in order.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (gpi_press !== 4'h0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL press_unexpected: got gpi_press=%b, required no pulse", gpi_press);
      end else begin
        e = exp_q.pop_front();
        if (e.is_xfer || ({4'h0, gpi_press} !== e.data)) begin
          failures++;
          $display("FAIL press_event: got gpi_press=%b, required xfer=%b data=%h",
                   gpi_press, e.is_xfer, e.data);
        end
      end
    end
    if (din_val && din_rdy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got din=%h, required no transfer", din);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_xfer || (din !== e.data)) begin
          failures++;
          $display("FAIL xfer_event: got din=%h, required xfer=%b data=%h",
                   din, e.is_xfer, e.data);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    key_raw     = 4'hF;
    sw_raw      = 8'h00;
    din_rdy     = 1'b0;
    overrun_clr = 1'b0;

    // 1: reset state, and no spurious press after release
    tick(3);
    check("rst_gpi", {4'h0, gpi}, 8'h00);
    check("rst_gpi_press", {4'h0, gpi_press}, 8'h00);
    check("rst_din", din, 8'h00);
    check("rst_din_val", {7'h0, din_val}, 8'h00);
    check("rst_overrun", {7'h0, overrun}, 8'h00);
    reset = 1'b0;
    tick(20);
    check("idle_gpi", {4'h0, gpi}, 8'h00);

    // 2: bouncing key 1 gives one press, 6 cycles after the final edge
    for (int i = 0; i < 6; i++) begin
      key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    push_press(4'b0010);
    key_raw[1] = 1'b0;
    tick(5);
    check("bounce_gpi_early", {4'h0, gpi}, 8'h00);
    tick(1);
    check("bounce_gpi_on", {4'h0, gpi}, 8'h02);
    tick(3);
    key_raw[1] = 1'b1;
    tick(5);
    check("release_gpi_early", {4'h0, gpi}, 8'h02);
    tick(1);
    check("release_gpi_off", {4'h0, gpi}, 8'h00);
    tick(4);

    // 3: capture A5, hold while not ready, then transfer
    sw_raw = 8'hA5;
    tick(3);
    push_press(4'b0001);
    key_raw[0] = 1'b0;
    tick(7);
    check("cap_din", din, 8'hA5);
    check("cap_din_val", {7'h0, din_val}, 8'h01);
    key_raw[0] = 1'b1;
    tick(10);
    check("hold_din", din, 8'hA5);
    check("hold_din_val", {7'h0, din_val}, 8'h01);
    push_xfer(8'hA5);
    din_rdy = 1'b1;
    tick(1);
    din_rdy = 1'b0;
    check("xfer_din_val", {7'h0, din_val}, 8'h00);
    check("xfer_din_keep", din, 8'hA5);
    tick(3);

    // 4: refill with A5, then a dropped press sets overrun
    push_press(4'b0001);
    key_raw[0] = 1'b0;
    tick(7);
    check("refill_din_val", {7'h0, din_val}, 8'h01);
    key_raw[0] = 1'b1;
    tick(8);
    sw_raw = 8'h3C;
    push_press(4'b0001);
    key_raw[0] = 1'b0;
    tick(7);
    check("drop_din", din, 8'hA5);
    check("drop_overrun", {7'h0, overrun}, 8'h01);
    key_raw[0] = 1'b1;
    tick(8);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("clr_overrun", {7'h0, overrun}, 8'h00);
    push_press(4'b0001);
    key_raw[0] = 1'b0;
    tick(6);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("setwins_overrun", {7'h0, overrun}, 8'h01);
    check("setwins_din", din, 8'hA5);
    key_raw[0] = 1'b1;
    tick(8);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("clr2_overrun", {7'h0, overrun}, 8'h00);

    // 5: press and transfer in the same cycle refill with no bubble
    push_press(4'b0001);
    push_xfer(8'hA5);
    key_raw[0] = 1'b0;
    tick(6);
    din_rdy = 1'b1;
    tick(1);
    din_rdy = 1'b0;
    check("nobubble_din", din, 8'h3C);
    check("nobubble_din_val", {7'h0, din_val}, 8'h01);
    check("nobubble_overrun", {7'h0, overrun}, 8'h00);
    key_raw[0] = 1'b1;
    tick(8);

    // 6: reset while full and key 2 mid-debounce
    key_raw[2] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_din_val", {7'h0, din_val}, 8'h00);
    check("midrst_din", din, 8'h00);
    check("midrst_gpi", {4'h0, gpi}, 8'h00);
    push_press(4'b0100);
    tick(5);
    check("postrst_gpi_early", {4'h0, gpi}, 8'h00);
    tick(1);
    check("postrst_gpi_on", {4'h0, gpi}, 8'h04);
    key_raw[2] = 1'b1;
    tick(8);

    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL events_pending: got %0d outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
